// File: rtl/control_sequencer.sv
// control_sequencer: instruction FSM with integrated control decode, memory-ready timeout, HALT and sticky FAULT
module control_sequencer #(
    parameter int OPC_W       = 8,
    parameter int ALU_W       = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int ALU_ADD     = 1,
    parameter int ALU_MUL     = 2,
    parameter int OP_NOP      = 0,
    parameter int OP_CLAC     = 1,
    parameter int OP_LDAC     = 2,
    parameter int OP_STAC     = 3,
    parameter int OP_MVACR    = 4,
    parameter int OP_MVRAC    = 5,
    parameter int OP_ADD      = 6,
    parameter int OP_MUL      = 7,
    parameter int OP_JMP      = 8,
    parameter int OP_JMPZ     = 9,
    parameter int OP_HALT     = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [OPC_W-1:0] opcode,
    input  logic             z_flag,
    input  logic             mem_ready,
    output logic [5:0]       state,
    output logic [3:0]       bus_sel,
    output logic             ld_ar,
    output logic             ld_ir,
    output logic             ld_dr,
    output logic             ld_r,
    output logic             ld_ac,
    output logic             clr_ac,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [ALU_W-1:0] alu_op,
    output logic             busy,
    output logic             halted,
    output logic             fault
);
    localparam int CNT_W = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [5:0] {
        S_IDLE   = 6'd0,  S_FETCH1 = 6'd1,  S_FETCH2 = 6'd2,  S_FETCH3 = 6'd3,
        S_DECODE = 6'd4,  S_CLAC   = 6'd5,  S_LDAC1  = 6'd6,  S_LDAC2  = 6'd7,
        S_LDAC3  = 6'd8,  S_STAC1  = 6'd9,  S_STAC2  = 6'd10, S_MVACR  = 6'd11,
        S_MVRAC  = 6'd12, S_ADD    = 6'd13, S_MUL    = 6'd14, S_JMP    = 6'd15,
        S_JMPZ   = 6'd16, S_HALT   = 6'd17, S_FAULT  = 6'd18
    } state_t;

    state_t cur, nxt;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic tmo, wait_st;

    // The cycle that would bring the counter to the limit is the last allowed wait
    assign tmo     = (MEM_TIMEOUT != 0) && (cnt == CNT_W'(MEM_TIMEOUT - 1));
    assign wait_st = cur inside {S_FETCH2, S_LDAC2, S_STAC2};
    assign state   = cur;
    assign busy    = !(cur inside {S_IDLE, S_HALT, S_FAULT});
    assign halted  = cur == S_HALT;
    assign fault   = cur == S_FAULT;

    always_ff @(posedge clock) begin
        if (reset) begin
            cur <= S_IDLE;
            cnt <= '0;
        end else begin
            cur <= nxt;
            cnt <= cnt_n;
        end
    end

    always_comb begin
        nxt     = cur;
        bus_sel = 4'd0;
        ld_ar   = 1'b0;
        ld_ir   = 1'b0;
        ld_dr   = 1'b0;
        ld_r    = 1'b0;
        ld_ac   = 1'b0;
        clr_ac  = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        alu_op  = '0;
        case (cur)
            S_IDLE:   nxt = start ? S_FETCH1 : S_IDLE;
            S_FETCH1: begin bus_sel = 4'd1; ld_ar = 1'b1; nxt = S_FETCH2; end
            S_FETCH2: begin
                bus_sel = 4'd6;
                mem_rd  = 1'b1;
                ld_dr   = mem_ready;
                pc_inc  = mem_ready;
                nxt     = mem_ready ? S_FETCH3 : tmo ? S_FAULT : S_FETCH2;
            end
            S_FETCH3: begin bus_sel = 4'd2; ld_ir = 1'b1; nxt = S_DECODE; end
            S_DECODE: begin
                case (opcode)
                    OPC_W'(OP_NOP):   nxt = S_FETCH1;
                    OPC_W'(OP_CLAC):  nxt = S_CLAC;
                    OPC_W'(OP_LDAC):  nxt = S_LDAC1;
                    OPC_W'(OP_STAC):  nxt = S_STAC1;
                    OPC_W'(OP_MVACR): nxt = S_MVACR;
                    OPC_W'(OP_MVRAC): nxt = S_MVRAC;
                    OPC_W'(OP_ADD):   nxt = S_ADD;
                    OPC_W'(OP_MUL):   nxt = S_MUL;
                    OPC_W'(OP_JMP):   nxt = S_JMP;
                    OPC_W'(OP_JMPZ):  nxt = S_JMPZ;
                    OPC_W'(OP_HALT):  nxt = S_HALT;
                    default:          nxt = S_FAULT;
                endcase
            end
            S_CLAC:   begin clr_ac = 1'b1; nxt = S_FETCH1; end
            S_LDAC1:  begin bus_sel = 4'd2; ld_ar = 1'b1; nxt = S_LDAC2; end
            S_LDAC2:  begin
                bus_sel = 4'd6;
                mem_rd  = 1'b1;
                ld_dr   = mem_ready;
                nxt     = mem_ready ? S_LDAC3 : tmo ? S_FAULT : S_LDAC2;
            end
            S_LDAC3:  begin bus_sel = 4'd2; ld_ac = 1'b1; nxt = S_FETCH1; end
            S_STAC1:  begin bus_sel = 4'd2; ld_ar = 1'b1; nxt = S_STAC2; end
            S_STAC2:  begin
                bus_sel = 4'd4;
                mem_wr  = 1'b1;
                nxt     = mem_ready ? S_FETCH1 : tmo ? S_FAULT : S_STAC2;
            end
            S_MVACR:  begin bus_sel = 4'd4; ld_r = 1'b1; nxt = S_FETCH1; end
            S_MVRAC:  begin bus_sel = 4'd3; ld_ac = 1'b1; nxt = S_FETCH1; end
            S_ADD:    begin alu_op = ALU_W'(ALU_ADD); ld_ac = 1'b1; nxt = S_FETCH1; end
            S_MUL:    begin alu_op = ALU_W'(ALU_MUL); ld_ac = 1'b1; nxt = S_FETCH1; end
            S_JMP:    begin bus_sel = 4'd2; pc_load = 1'b1; nxt = S_FETCH1; end
            S_JMPZ:   begin bus_sel = 4'd2; pc_load = z_flag; nxt = S_FETCH1; end
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_FAULT;
        endcase
        cnt_n = (wait_st && nxt == cur) ? cnt + 1'b1 : '0;
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: expected cycle traces built per instruction from the ISA timing rules, replayed with random don't-care inputs
module tb_control_sequencer;
    logic clock, reset, start, z_flag, mem_ready;
    logic [7:0] opcode;
    logic [5:0] state;
    logic [3:0] bus_sel;
    logic ld_ar, ld_ir, ld_dr, ld_r, ld_ac, clr_ac, pc_inc, pc_load, mem_rd, mem_wr;
    logic [1:0] alu_op;
    logic busy, halted, fault;

    control_sequencer #(.MEM_TIMEOUT(4)) dut (
        .clock(clock), .reset(reset), .start(start), .opcode(opcode), .z_flag(z_flag),
        .mem_ready(mem_ready), .state(state), .bus_sel(bus_sel), .ld_ar(ld_ar), .ld_ir(ld_ir),
        .ld_dr(ld_dr), .ld_r(ld_r), .ld_ac(ld_ac), .clr_ac(clr_ac), .pc_inc(pc_inc),
        .pc_load(pc_load), .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_op(alu_op), .busy(busy),
        .halted(halted), .fault(fault)
    );

    localparam logic [9:0] AR = 10'h200, IR = 10'h100, DR = 10'h080, RR = 10'h040, AC = 10'h020;
    localparam logic [9:0] CL = 10'h010, PI = 10'h008, PL = 10'h004, RD = 10'h002, WR = 10'h001;

    typedef struct {
        logic [5:0] st;
        logic [3:0] bus;
        logic [9:0] stb;
        logic [1:0] alu;
        logic rdy, z, rst, go;
        logic [7:0] op;
    } cyc_t;

    cyc_t q[$];
    logic [7:0] cur_op;
    int checks = 0, errors = 0, cyc = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // rdy/z of -1 means the input is irrelevant in that cycle and is randomised
    function automatic void push(input logic [5:0] st, input logic [3:0] bus, input logic [9:0] stb,
                                 input logic [1:0] alu, input int rdy, input int z);
        cyc_t r;
        r.st  = st;
        r.bus = bus;
        r.stb = stb;
        r.alu = alu;
        r.rdy = rdy < 0 ? 1'($urandom) : 1'(rdy);
        r.z   = z < 0 ? 1'($urandom) : 1'(z);
        r.rst = 1'b0;
        r.go  = st == 6'd0 ? 1'b0 : 1'($urandom);
        r.op  = st == 6'd4 ? cur_op : 8'($urandom);
        q.push_back(r);
    endfunction

    function automatic void gen_fetch(input logic [7:0] op, input int wf);
        cur_op = op;
        push(6'd1, 4'd1, AR, 2'd0, -1, -1);
        for (int i = 0; i < wf; i++) push(6'd2, 4'd6, RD, 2'd0, 0, -1);
        push(6'd2, 4'd6, RD | DR | PI, 2'd0, 1, -1);
        push(6'd3, 4'd2, IR, 2'd0, -1, -1);
        push(6'd4, 4'd0, 10'h0, 2'd0, -1, -1);
    endfunction

    function automatic void gen_instr(input logic [7:0] op, input int wf, input int wm, input int z);
        gen_fetch(op, wf);
        case (op)
            8'd1: push(6'd5, 4'd0, CL, 2'd0, -1, -1);
            8'd2: begin
                push(6'd6, 4'd2, AR, 2'd0, -1, -1);
                for (int i = 0; i < wm; i++) push(6'd7, 4'd6, RD, 2'd0, 0, -1);
                push(6'd7, 4'd6, RD | DR, 2'd0, 1, -1);
                push(6'd8, 4'd2, AC, 2'd0, -1, -1);
            end
            8'd3: begin
                push(6'd9, 4'd2, AR, 2'd0, -1, -1);
                for (int i = 0; i < wm; i++) push(6'd10, 4'd4, WR, 2'd0, 0, -1);
                push(6'd10, 4'd4, WR, 2'd0, 1, -1);
            end
            8'd4: push(6'd11, 4'd4, RR, 2'd0, -1, -1);
            8'd5: push(6'd12, 4'd3, AC, 2'd0, -1, -1);
            8'd6: push(6'd13, 4'd0, AC, 2'd1, -1, -1);
            8'd7: push(6'd14, 4'd0, AC, 2'd2, -1, -1);
            8'd8: push(6'd15, 4'd2, PL, 2'd0, -1, -1);
            8'd9: push(6'd16, 4'd2, z != 0 ? PL : 10'h0, 2'd0, -1, z);
            default: ;
        endcase
    endfunction

    function automatic void idle_start();
        push(6'd0, 4'd0, 10'h0, 2'd0, -1, -1);
        q[q.size() - 1].go = 1'b1;
    endfunction

    function automatic void mark_reset();
        q[q.size() - 1].rst = 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic run_q();
        cyc_t r;
        logic [2:0] flags;
        while (q.size() > 0) begin
            r = q.pop_front();
            @(negedge clock);
            reset = r.rst;
            start = r.go;
            opcode = r.op;
            z_flag = r.z;
            mem_ready = r.rdy;
            #1;
            cyc++;
            flags = {r.st != 6'd0 && r.st != 6'd17 && r.st != 6'd18, r.st == 6'd17, r.st == 6'd18};
            chk("state", 16'(state), 16'(r.st));
            chk("bus_sel", 16'(bus_sel), 16'(r.bus));
            chk("strobes", 16'({ld_ar, ld_ir, ld_dr, ld_r, ld_ac, clr_ac, pc_inc, pc_load, mem_rd, mem_wr}), 16'(r.stb));
            chk("alu_op", 16'(alu_op), 16'(r.alu));
            chk("busy_halted_fault", 16'({busy, halted, fault}), 16'(flags));
            chk("rd_wr_exclusive", 16'(mem_rd & mem_wr), 16'd0);
            chk("inc_load_exclusive", 16'(pc_inc & pc_load), 16'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        opcode = 8'd0;
        z_flag = 1'b0;
        mem_ready = 1'b0;
        cur_op = 8'd0;
        repeat (2) @(posedge clock);
        push(6'd0, 4'd0, 10'h0, 2'd0, -1, -1);
        mark_reset();
        push(6'd0, 4'd0, 10'h0, 2'd0, -1, -1);
        idle_start();
        gen_instr(8'd1, 0, 0, 0);
        gen_instr(8'd2, 0, 3, 0);
        gen_instr(8'd9, 0, 0, 0);
        gen_instr(8'd9, 0, 0, 1);
        gen_instr(8'd6, 0, 0, 0);
        gen_instr(8'd7, 0, 0, 0);
        gen_instr(8'd0, 0, 0, 0);
        gen_instr(8'd3, 1, 2, 0);
        gen_instr(8'd4, 3, 0, 0);
        gen_instr(8'd5, 0, 0, 0);
        gen_instr(8'd8, 2, 0, 0);
        run_q();

        for (int n = 0; n < 40; n++)
            gen_instr(8'($urandom_range(0, 9)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 1)));
        run_q();

        gen_fetch(8'd15, 0);
        for (int i = 0; i < 10; i++) push(6'd17, 4'd0, 10'h0, 2'd0, -1, -1);
        mark_reset();
        idle_start();
        gen_fetch(8'd12, 1);
        for (int i = 0; i < 3; i++) push(6'd18, 4'd0, 10'h0, 2'd0, -1, -1);
        mark_reset();
        idle_start();
        push(6'd1, 4'd1, AR, 2'd0, -1, -1);
        for (int i = 0; i < 4; i++) push(6'd2, 4'd6, RD, 2'd0, 0, -1);
        for (int i = 0; i < 4; i++) push(6'd18, 4'd0, 10'h0, 2'd0, -1, -1);
        mark_reset();
        idle_start();
        gen_fetch(8'd3, 0);
        push(6'd9, 4'd2, AR, 2'd0, -1, -1);
        push(6'd10, 4'd4, WR, 2'd0, 0, -1);
        push(6'd10, 4'd4, WR, 2'd0, 0, -1);
        mark_reset();
        idle_start();
        gen_instr(8'd3, 3, 3, 0);
        gen_instr(8'd2, 3, 3, 0);
        run_q();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Parametrised successor to the processor control unit.
- Integrates the instruction state machine with control-signal decode, so no external state input is needed.
- Adds a memory-ready handshake with timeout, conditional branching on the zero flag, HALT, and a sticky FAULT state.
- Sits between the IR/flags and the datapath (AR, IR, DR, R, PC, AC, ALU, memory).

Parameters:
OPC_W, 8, opcode width
ALU_W, 2, alu_op width
MEM_TIMEOUT, 15, max mem_ready wait cycles; 0 disables timeout
ALU_ADD, 1, alu_op code for ADD
ALU_MUL, 2, alu_op code for MUL
OP_NOP/CLAC/LDAC/STAC/MVACR/MVRAC/ADD/MUL/JMP/JMPZ/HALT, 0/1/2/3/4/5/6/7/8/9/15, opcode encodings

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  leave IDLE
opcode  in  OPC_W  IR contents
z_flag  in  1  AC==0 from datapath
mem_ready  in  1  memory access completes this cycle
state  out  6  current state code
bus_sel  out  4  0 none, 1 PC, 2 DR, 3 R, 4 AC, 6 MEM
ld_ar, ld_ir, ld_dr, ld_r, ld_ac, clr_ac, pc_inc, pc_load, mem_rd, mem_wr  out  1 each  datapath strobes
alu_op  out  ALU_W  ALU operation
busy  out  1  state not in IDLE, HALT or FAULT
halted  out  1  state==HALT
fault  out  1  state==FAULT

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE(0), wait counter=0.
  - All strobes 0, bus_sel=0, alu_op=0, busy/halted/fault=0.
  - Reset overrides every other input in any state, including mid-wait.
- State codes: IDLE 0, FETCH1 1, FETCH2 2, FETCH3 3, DECODE 4, CLAC 5, LDAC1 6, LDAC2 7, LDAC3 8, STAC1 9, STAC2 10, MVACR 11, MVRAC 12, ADD 13, MUL 14, JMP 15, JMPZ 16, HALT 17, FAULT 18.
- Output timing:
  - Outputs are a Moore decode of the state register.
  - Exception: ld_dr and pc_inc in FETCH2, and ld_dr in LDAC2, are additionally ANDed with mem_ready.
- Transitions and per-state outputs:
  - IDLE: all 0; go FETCH1 when start=1, else stay.
  - FETCH1: bus_sel=1, ld_ar → FETCH2.
  - FETCH2: mem_rd=1, bus_sel=6; on mem_ready: ld_dr, pc_inc → FETCH3; else stay.
  - FETCH3: bus_sel=2, ld_ir → DECODE. DR keeps the instruction word; its low bits are the address/target field.
  - DECODE: no strobes; branch on opcode:
    - NOP → FETCH1; CLAC/LDAC1/STAC1/MVACR/MVRAC/ADD/MUL/JMP/JMPZ per code; HALT → HALT.
    - Any unlisted opcode → FAULT.
  - CLAC: clr_ac.
  - LDAC1: bus_sel=2, ld_ar → LDAC2.
  - LDAC2: mem_rd, bus_sel=6; on mem_ready: ld_dr → LDAC3.
  - LDAC3: bus_sel=2, ld_ac.
  - STAC1: bus_sel=2, ld_ar → STAC2.
  - STAC2: bus_sel=4, mem_wr held until mem_ready.
  - MVACR: bus_sel=4, ld_r.
  - MVRAC: bus_sel=3, ld_ac.
  - ADD: alu_op=ALU_ADD, ld_ac.
  - MUL: alu_op=ALU_MUL, ld_ac.
  - JMP: bus_sel=2, pc_load.
  - JMPZ: bus_sel=2, pc_load=z_flag. The z_flag sampled in this state is decisive.
  - Terminal execute states (CLAC, LDAC3, STAC2 on ready, MVACR, MVRAC, ADD, MUL, JMP, JMPZ) → FETCH1.
- Memory wait (FETCH2, LDAC2, STAC2):
  - Counter increments each cycle with mem_ready=0; cleared on leaving the state.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with mem_ready still 0 → FAULT.
  - mem_ready=1 in the same cycle the counter would hit the limit: completion wins.
- HALT and FAULT: sticky until reset; start ignored; all strobes 0.
- Cycles per instruction with zero-wait memory:
  - CLAC/MVACR/MVRAC/ADD/MUL/JMP/JMPZ/NOP(no exec state): 5 (NOP 4).
  - LDAC: 7. STAC: 6.
- Invariants:
  - mem_rd and mem_wr are never both 1.
  - pc_inc and pc_load are never both 1.

Test Plan:
- Reset then start=1 one cycle, opcode=1, mem_ready=1 → states 1,2,3,4,5,1; clr_ac=1 only in state 5; busy=1 from cycle after start.
- LDAC with mem_ready low 3 cycles in LDAC2 → mem_rd held 4 cycles, ld_dr single pulse with mem_ready, then LDAC3 with ld_ac=1, bus_sel=2.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH2 → FAULT after 4 wait cycles, fault=1, busy=0; start ignored; reset → IDLE, all outputs 0.
- JMPZ with z_flag=0 then 1 → pc_load 0 then 1 with bus_sel=2; ADD/MUL → alu_op 1/2 with ld_ac=1.
- opcode=15 → HALT, halted=1 held 10 cycles; opcode=12 → FAULT.
- Reset asserted mid-STAC2 with mem_wr=1 → next cycle state=0, mem_wr=0, counter 0; assert invariants every cycle.
